mem_arbiter: RTL

//  Shares the single multi-cycle main memory between the I-cache fill path, the
//  D-cache fill path and D-cache write-through stores. Sits between both cache

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between I-cache fills, D-cache fills and D-cache stores.
// Define ARB_RR_EN to alternate between I and D when both fill requests are pending.
module mem_arbiter #(
   parameter int  AWIDTH  = 16,
   parameter int  DWIDTH  = 16,
   parameter int  WORDS   = 8,
   parameter int  MEM_LAT = 4,
   localparam int IW      = $clog2(WORDS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              i_req_i,
   input  logic [AWIDTH-1:0] i_addr_i,
   input  logic              d_req_i,
   input  logic [AWIDTH-1:0] d_addr_i,
   input  logic              d_wr_req_i,
   input  logic [AWIDTH-1:0] d_wr_addr_i,
   input  logic [DWIDTH-1:0] d_wr_data_i,
   output logic              mem_en_o,
   output logic              mem_wr_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_wdata_o,
   input  logic [DWIDTH-1:0] mem_rdata_i,
   input  logic              mem_valid_i,
   output logic [DWIDTH-1:0] fill_data_o,
   output logic [IW-1:0]     fill_idx_o,
   output logic              i_fill_valid_o,
   output logic              d_fill_valid_o,
   output logic              i_done_o,
   output logic              d_done_o,
   output logic              d_wr_ack_o
);
   localparam int OFF = IW + 1;
   localparam int BW  = AWIDTH - OFF;
   localparam int DCW = $clog2(MEM_LAT + 1);
   localparam logic [IW-1:0]  LAST_WORD  = IW'(WORDS - 1);
   localparam logic [DCW-1:0] LAST_DRAIN = DCW'(MEM_LAT - 1);

   typedef enum logic [2:0] {DRAIN, IDLE, WRITE, FILL_I, FILL_D} state_t;

   state_t            state_q;
   state_t            grant_d;
   logic [DCW-1:0]    drainCnt_q;
   logic [IW-1:0]     txCnt_q;
   logic [IW-1:0]     rxCnt_q;
   logic [IW-1:0]     txNext_d;
   logic [BW-1:0]     fillBase_q;
   logic [BW-1:0]     fillBase_d;
   logic              memEn_q;
   logic              memWr_q;
   logic [AWIDTH-1:0] memAddr_q;
   logic [DWIDTH-1:0] memWdata_q;
   logic              wrAck_q;
   logic              unused_addrBits;
`ifdef ARB_RR_EN
   logic              lastGrantD_q;
`endif

   // Fills always start at word 0 of the block, so the byte offset of a miss address is irrelevant.
   assign unused_addrBits = ^{i_addr_i[OFF-1:0], d_addr_i[OFF-1:0]};
   assign txNext_d        = txCnt_q + 1'b1;

   always_comb begin
      grant_d = IDLE;
      if (d_wr_req_i) begin
         grant_d = WRITE;
      end else if (d_req_i && i_req_i) begin
`ifdef ARB_RR_EN
         grant_d = lastGrantD_q ? FILL_I : FILL_D;
`else
         grant_d = FILL_D;
`endif
      end else if (d_req_i) begin
         grant_d = FILL_D;
      end else if (i_req_i) begin
         grant_d = FILL_I;
      end
      fillBase_d = (grant_d == FILL_D) ? d_addr_i[AWIDTH-1:OFF] : i_addr_i[AWIDTH-1:OFF];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= DRAIN;
         drainCnt_q <= '0;
         txCnt_q    <= '0;
         rxCnt_q    <= '0;
         fillBase_q <= '0;
         memEn_q    <= 1'b0;
         memWr_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         wrAck_q    <= 1'b0;
`ifdef ARB_RR_EN
         lastGrantD_q <= 1'b0;
`endif
      end else begin
         memWr_q    <= 1'b0;
         memWdata_q <= '0;
         wrAck_q    <= 1'b0;
         case (state_q)
            // Reads issued before reset may still return; wait them out before granting.
            DRAIN: begin
               if (drainCnt_q == LAST_DRAIN) begin
                  drainCnt_q <= '0;
                  state_q    <= IDLE;
               end else begin
                  drainCnt_q <= drainCnt_q + 1'b1;
               end
            end
            IDLE: begin
               memEn_q   <= 1'b0;
               memAddr_q <= '0;
               case (grant_d)
                  WRITE: begin
                     state_q    <= WRITE;
                     memEn_q    <= 1'b1;
                     memWr_q    <= 1'b1;
                     memAddr_q  <= d_wr_addr_i;
                     memWdata_q <= d_wr_data_i;
                     wrAck_q    <= 1'b1;
                  end
                  FILL_I, FILL_D: begin
                     state_q    <= grant_d;
                     fillBase_q <= fillBase_d;
                     txCnt_q    <= '0;
                     rxCnt_q    <= '0;
                     memEn_q    <= 1'b1;
                     memAddr_q  <= {fillBase_d, {IW{1'b0}}, 1'b0};
`ifdef ARB_RR_EN
                     lastGrantD_q <= (grant_d == FILL_D);
`endif
                  end
                  default: ;
               endcase
            end
            WRITE: begin
               state_q   <= IDLE;
               memEn_q   <= 1'b0;
               memAddr_q <= '0;
            end
            FILL_I, FILL_D: begin
               if (memEn_q) begin
                  if (txCnt_q == LAST_WORD) begin
                     memEn_q   <= 1'b0;
                     memAddr_q <= '0;
                  end else begin
                     txCnt_q   <= txNext_d;
                     memAddr_q <= {fillBase_q, txNext_d, 1'b0};
                  end
               end
               if (mem_valid_i) begin
                  rxCnt_q <= rxCnt_q + 1'b1;
                  if (rxCnt_q == LAST_WORD) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= DRAIN;
         endcase
      end
   end

   // Returning words bypass the flops so each word is delivered in its data_valid cycle.
   assign mem_en_o       = memEn_q;
   assign mem_wr_o       = memWr_q;
   assign mem_addr_o     = memAddr_q;
   assign mem_wdata_o    = memWdata_q;
   assign d_wr_ack_o     = wrAck_q;
   assign fill_data_o    = mem_rdata_i;
   assign fill_idx_o     = rxCnt_q;
   assign i_fill_valid_o = mem_valid_i && (state_q == FILL_I);
   assign d_fill_valid_o = mem_valid_i && (state_q == FILL_D);
   assign i_done_o       = i_fill_valid_o && (rxCnt_q == LAST_WORD);
   assign d_done_o       = d_fill_valid_o && (rxCnt_q == LAST_WORD);

endmodule
